// File: rtl/mac_decomp_pkg.sv
// Shared types and constants for the MAC image decompressor SRAM path.
package mac_decomp_pkg;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 16;

    typedef enum logic [1:0] {REQ_NONE, REQ_VGA, REQ_DEC, REQ_UART} requester_id_t;

    typedef struct packed {
        logic          valid;
        requester_id_t id;
    } read_tag_t;

    // Bit order matches the rvalid bundle: {UART, DEC, VGA}.
    function automatic logic [2:0] tag_to_onehot(input read_tag_t tag);
        logic [2:0] oh;
        case (tag.id)
            REQ_VGA:  oh = 3'b001;
            REQ_DEC:  oh = 3'b010;
            REQ_UART: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return tag.valid ? oh : 3'b000;
    endfunction

endpackage

// File: rtl/sram_read_tag_pipe.sv
// Tracks outstanding reads as {valid, id} tags and returns SRAM data to the
// requester that issued each read, in grant order.
module sram_read_tag_pipe
    import mac_decomp_pkg::*;
#(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  read_tag_t         push_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [2:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);

    read_tag_t         tag_q [DEPTH];
    read_tag_t         tag_d [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // SRAM data is captured one stage before the tag reaches the output stage.
    always_comb begin
        tag_d[0] = push_i;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        rdata_d = tag_q[DEPTH-2].valid ? rd_data_i : rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
            rdata_q <= rdata_d;
        end
    end

    assign rvalid_o = tag_to_onehot(tag_q[DEPTH-1]);
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/sram_arbiter.sv
// Fixed-priority SRAM port arbiter (VGA > decoder > UART) with a starvation
// guard that promotes the UART above the decoder after MAX_WAIT blocked cycles.
module sram_arbiter
    import mac_decomp_pkg::*;
#(
    parameter int unsigned ADDR_W       = SRAM_ADDR_W,
    parameter int unsigned DATA_W       = SRAM_DATA_W,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_WAIT     = 8
) (
    input  logic              Clock_50,
    input  logic              Reset,
    input  logic [2:0]        Enable,
    input  logic              VGA_req,
    input  logic              DEC_req,
    input  logic              UART_req,
    input  logic [ADDR_W-1:0] VGA_addr,
    input  logic [ADDR_W-1:0] DEC_addr,
    input  logic [ADDR_W-1:0] UART_addr,
    input  logic              DEC_we,
    input  logic              UART_we,
    input  logic [DATA_W-1:0] DEC_wdata,
    input  logic [DATA_W-1:0] UART_wdata,
    output logic              VGA_grant,
    output logic              DEC_grant,
    output logic              UART_grant,
    output logic              VGA_rvalid,
    output logic              DEC_rvalid,
    output logic              UART_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n,
    input  logic [DATA_W-1:0] SRAM_read_data
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic              vga_ok, dec_ok, uart_ok, promoted;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_n_q, we_n_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    read_tag_t         push;

    always_comb begin
        vga_ok     = VGA_req & Enable[0];
        dec_ok     = DEC_req & Enable[1];
        uart_ok    = UART_req & Enable[2];
        promoted   = (wait_q == WAIT_W'(MAX_WAIT));
        VGA_grant  = ~Reset & vga_ok;
        DEC_grant  = ~Reset & ~vga_ok & dec_ok & ~(promoted & uart_ok);
        UART_grant = ~Reset & ~vga_ok & uart_ok & (promoted | ~dec_ok);
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        push    = '0;
        if (VGA_grant) begin
            addr_d = VGA_addr;
            push   = '{valid: 1'b1, id: REQ_VGA};
        end else if (DEC_grant) begin
            addr_d  = DEC_addr;
            wdata_d = DEC_wdata;
            we_n_d  = ~DEC_we;
            push    = '{valid: ~DEC_we, id: REQ_DEC};
        end else if (UART_grant) begin
            addr_d  = UART_addr;
            wdata_d = UART_wdata;
            we_n_d  = ~UART_we;
            push    = '{valid: ~UART_we, id: REQ_UART};
        end

        // Only decoder wins count as blocking; VGA cycles leave the count alone.
        wait_d = wait_q;
        if (UART_grant || !UART_req) begin
            wait_d = '0;
        end else if (uart_ok && DEC_grant && !promoted) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            wait_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
            wait_q  <= wait_d;
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;

    sram_read_tag_pipe #(
        .DEPTH  (READ_LATENCY + 1),
        .DATA_W (DATA_W)
    ) u_tag_pipe (
        .clk_i     (Clock_50),
        .rst_i     (Reset),
        .push_i    (push),
        .rd_data_i (SRAM_read_data),
        .rvalid_o  ({UART_rvalid, DEC_rvalid, VGA_rvalid}),
        .rdata_o   (rdata)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the arbitration rules.
module tb_sram_arbiter;
    localparam int MAX_WAIT = 8;
    localparam int RD_LAT   = 2;

    logic        Clock_50 = 1'b0;
    logic        Reset;
    logic [2:0]  Enable;
    logic        VGA_req, DEC_req, UART_req;
    logic [17:0] VGA_addr, DEC_addr, UART_addr;
    logic        DEC_we, UART_we;
    logic [15:0] DEC_wdata, UART_wdata;
    logic        VGA_grant, DEC_grant, UART_grant;
    logic        VGA_rvalid, DEC_rvalid, UART_rvalid;
    logic [15:0] rdata, SRAM_write_data, SRAM_read_data;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;

    sram_arbiter dut (
        .Clock_50(Clock_50), .Reset(Reset), .Enable(Enable),
        .VGA_req(VGA_req), .DEC_req(DEC_req), .UART_req(UART_req),
        .VGA_addr(VGA_addr), .DEC_addr(DEC_addr), .UART_addr(UART_addr),
        .DEC_we(DEC_we), .UART_we(UART_we), .DEC_wdata(DEC_wdata), .UART_wdata(UART_wdata),
        .VGA_grant(VGA_grant), .DEC_grant(DEC_grant), .UART_grant(UART_grant),
        .VGA_rvalid(VGA_rvalid), .DEC_rvalid(DEC_rvalid), .UART_rvalid(UART_rvalid),
        .rdata(rdata), .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
    );

    always #5 Clock_50 = ~Clock_50;

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 40503 + 17);
    endfunction

    // External SRAM: writes commit at the edge, reads return one cycle after the address.
    logic [15:0] sram [0:262143];
    logic [15:0] sram_rd_q;
    logic        mem_ready = 1'b0;
    always @(posedge Clock_50) begin
        if (!mem_ready) begin
            for (int i = 0; i < 262144; i++) sram[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else begin
            if (!SRAM_we_n) sram[SRAM_address] <= SRAM_write_data;
            sram_rd_q <= sram[SRAM_address];
        end
    end
    assign SRAM_read_data = sram_rd_q;

    // Reference model state
    typedef struct {
        int          due;
        int          id;
        logic [15:0] data;
    } exp_rd_t;

    logic [15:0] ref_mem [0:262143];
    exp_rd_t     rq [$];
    int          m_wait;
    logic        m_we_n;
    logic [17:0] m_addr;
    logic [15:0] m_wdata;
    int          cyc;
    logic [2:0]  last_grant;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit wants(input int id);
        case (id)
            1: return VGA_req & Enable[0];
            2: return DEC_req & Enable[1];
            3: return UART_req & Enable[2];
            default: return 1'b0;
        endcase
    endfunction

    // 1=VGA, 2=DEC, 3=UART, 0=none
    function automatic int model_grant();
        int order [3];
        if (Reset) return 0;
        if (m_wait >= MAX_WAIT) order = '{1, 3, 2};
        else order = '{1, 2, 3};
        foreach (order[i]) if (wants(order[i])) return order[i];
        return 0;
    endfunction

    // One clock cycle: compare at the falling edge, advance the model, return at posedge+1.
    task automatic step();
        int          g;
        logic [2:0]  exp_rv;
        logic [15:0] exp_rd;
        logic [17:0] a;
        logic        w;
        logic [15:0] d;
        exp_rd_t     e;
        @(negedge Clock_50);
        g = model_grant();
        last_grant = {UART_grant, DEC_grant, VGA_grant};
        check_eq("grant", 32'(last_grant), (g == 0) ? 0 : (1 << (g - 1)));
        check_eq("we_n", 32'(SRAM_we_n), 32'(m_we_n));
        check_eq("address", 32'(SRAM_address), 32'(m_addr));
        check_eq("write_data", 32'(SRAM_write_data), 32'(m_wdata));
        exp_rv = 3'b000;
        exp_rd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_rv = 3'(1 << (rq[0].id - 1));
            exp_rd = rq[0].data;
            void'(rq.pop_front());
        end
        check_eq("rvalid", 32'({UART_rvalid, DEC_rvalid, VGA_rvalid}), 32'(exp_rv));
        if (exp_rv != 3'b000) check_eq("rdata", 32'(rdata), 32'(exp_rd));

        if (Reset) begin
            rq.delete();
            m_we_n  = 1'b1;
            m_addr  = '0;
            m_wdata = '0;
            m_wait  = 0;
        end else begin
            m_we_n = 1'b1;
            if (g != 0) begin
                case (g)
                    1: begin a = VGA_addr;  w = 1'b0;    d = m_wdata;    end
                    2: begin a = DEC_addr;  w = DEC_we;  d = DEC_wdata;  end
                    default: begin a = UART_addr; w = UART_we; d = UART_wdata; end
                endcase
                m_addr  = a;
                m_wdata = d;
                m_we_n  = ~w;
                if (w) begin
                    ref_mem[a] = d;
                end else begin
                    e.due  = cyc + RD_LAT + 1;
                    e.id   = g;
                    e.data = ref_mem[a];
                    rq.push_back(e);
                end
            end
            if (g == 3 || !UART_req) m_wait = 0;
            else if (UART_req && Enable[2] && g == 2) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : m_wait;
        end
        cyc++;
        @(posedge Clock_50);
        #1;
        case (g)
            1: VGA_req = 1'b0;
            2: DEC_req = 1'b0;
            3: UART_req = 1'b0;
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic starve_run(input string tag);
        int hit;
        hit = -1;
        UART_req = 1'b1; UART_addr = 18'h00777; UART_we = 1'b1; UART_wdata = 16'h5A5A;
        for (int k = 0; k < 20 && hit < 0; k++) begin
            DEC_req = 1'b1; DEC_addr = 18'(k); DEC_we = 1'b0;
            step();
            if (last_grant[2]) hit = k;
        end
        DEC_req = 1'b0;
        check_eq(tag, 32'(hit), 32'(MAX_WAIT));
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) ref_mem[i] = init_word(i);
        Reset = 1'b1; Enable = 3'b111;
        VGA_req = 0; DEC_req = 0; UART_req = 0;
        VGA_addr = '0; DEC_addr = '0; UART_addr = '0;
        DEC_we = 0; UART_we = 0; DEC_wdata = '0; UART_wdata = '0;
        m_wait = 0; m_we_n = 1'b1; m_addr = '0; m_wdata = '0; cyc = 0; last_grant = '0;
        repeat (3) @(posedge Clock_50);
        #1;
        step();
        Reset = 1'b0;

        // Idle after reset
        idle(4);
        check_eq("idle_rdata", 32'(rdata), 32'h0);

        // Single decoder read of a word written earlier
        UART_req = 1; UART_addr = 18'h00010; UART_we = 1; UART_wdata = 16'hBEEF;
        step();
        idle(4);
        DEC_req = 1; DEC_addr = 18'h00010; DEC_we = 0;
        idle(5);

        // All three in the same cycle
        VGA_req = 1;  VGA_addr = 18'h00100;
        DEC_req = 1;  DEC_addr = 18'h00200; DEC_we = 0;
        UART_req = 1; UART_addr = 18'h00300; UART_we = 1; UART_wdata = 16'h1234;
        idle(7);
        check_eq("word_300", 32'(sram[18'h00300]), 32'h1234);

        // Starvation guard, twice to confirm the count restarts from zero
        starve_run("starve_first");
        idle(4);
        starve_run("starve_again");
        idle(4);

        // Write then read the same address on consecutive grants
        UART_req = 1; UART_addr = 18'h05000; UART_we = 1; UART_wdata = 16'hA5A5;
        step();
        DEC_req = 1; DEC_addr = 18'h05000; DEC_we = 0;
        idle(5);

        // Reset one cycle after a VGA read grant
        VGA_req = 1; VGA_addr = 18'h00123;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_eq("rst_rdata", 32'(rdata), 32'h0);
        idle(6);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            Reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0)
                Enable = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
            if (!VGA_req && $urandom_range(0, 99) < 25) begin
                VGA_req = 1; VGA_addr = 18'($urandom_range(0, 15));
            end
            if (!DEC_req && $urandom_range(0, 99) < 60) begin
                DEC_req = 1; DEC_addr = 18'($urandom_range(0, 15));
                DEC_we = 1'($urandom); DEC_wdata = 16'($urandom);
            end
            if (!UART_req && $urandom_range(0, 99) < 40) begin
                UART_req = 1; UART_addr = 18'($urandom_range(0, 15));
                UART_we = 1'($urandom); UART_wdata = 16'($urandom);
            end
            step();
        end
        Reset = 1'b0; Enable = 3'b111;
        VGA_req = 0; DEC_req = 0; UART_req = 0;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
